// File: rtl/shift_pkg.sv
// Shared definitions for the shared-shifter scheduler: op encodings, widths,
// the in-flight tracking record and the bit-reversal helper.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic rev;
  } track_t;

  function automatic logic [DATA_W-1:0] bit_reverse32(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_rr_arb.sv
// Two-way arbiter for the shared shifter: round-robin when FAIR=1,
// fixed priority to port A when FAIR=0. The last grant moves only on a handshake.
module shift_rr_arb
  import shift_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic grant_a,
  output logic grant_b
);

  logic last_b_r;
  logic grant_a_s;
  logic grant_b_s;

  // Grant selection; a grant always implies the matching valid
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (a_valid && b_valid) begin
      if (FAIR && !last_b_r) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b1;
      end
    end else if (a_valid) begin
      grant_a_s = 1'b1;
    end else if (b_valid) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Last-grant register; resets to B so A wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_r <= PORT_B;
    end else if (grant_a_s || grant_b_s) begin
      last_b_r <= grant_b_s;
    end
  end

  assign grant_a = grant_a_s;
  assign grant_b = grant_b_s;

endmodule

// File: rtl/shift_unit_sched.sv
// Shares one external right shifter/rotator between ports A and B, adds left
// ops via operand/result bit reversal and routes each result back to its issuer.
module shift_unit_sched
  import shift_pkg::*;
#(
  parameter int SH_LATENCY = 1,
  parameter bit FAIR       = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic [AMT_W-1:0]  a_amt,
  input  logic [1:0]        a_op,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic [AMT_W-1:0]  b_amt,
  input  logic [1:0]        b_op,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic [DATA_W-1:0] sh_in,
  output logic              sh_rotate,
  output logic [AMT_W-1:0]  sh_select,
  input  logic [DATA_W-1:0] sh_out,
  output logic              busy
);

  logic              grant_a_s, grant_b_s, hs_s;
  logic [DATA_W-1:0] iss_data_s, iss_in_s, result_s;
  logic [AMT_W-1:0]  iss_amt_s;
  logic [1:0]        iss_op_s;
  logic [DATA_W-1:0] hold_in_r;
  logic              hold_rot_r;
  logic [AMT_W-1:0]  hold_sel_r;
  track_t            iss_entry_s, end_s;
  logic              pipe_busy_s;
  logic              a_rsp_valid_r, b_rsp_valid_r;
  logic [DATA_W-1:0] a_rsp_data_r, b_rsp_data_r;

  shift_rr_arb #(.FAIR(FAIR)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .grant_a (grant_a_s),
    .grant_b (grant_b_s)
  );

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;
  assign hs_s    = grant_a_s | grant_b_s;

  // Select the granted request
  always_comb begin
    iss_data_s = a_data;
    iss_amt_s  = a_amt;
    iss_op_s   = a_op;
    if (grant_b_s) begin
      iss_data_s = b_data;
      iss_amt_s  = b_amt;
      iss_op_s   = b_op;
    end else begin
      iss_data_s = a_data;
      iss_amt_s  = a_amt;
      iss_op_s   = a_op;
    end
  end

  assign iss_in_s = iss_op_s[1] ? bit_reverse32(iss_data_s) : iss_data_s;

  // Hold copy keeps the shifter inputs quiet between handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_in_r  <= '0;
      hold_rot_r <= 1'b0;
      hold_sel_r <= '0;
    end else if (hs_s) begin
      hold_in_r  <= iss_in_s;
      hold_rot_r <= iss_op_s[0];
      hold_sel_r <= iss_amt_s;
    end
  end

  // Shifter drive: fresh operands on a handshake, otherwise the hold copy
  always_comb begin
    sh_in     = hold_in_r;
    sh_rotate = hold_rot_r;
    sh_select = hold_sel_r;
    if (hs_s) begin
      sh_in     = iss_in_s;
      sh_rotate = iss_op_s[0];
      sh_select = iss_amt_s;
    end else begin
      sh_in     = hold_in_r;
      sh_rotate = hold_rot_r;
      sh_select = hold_sel_r;
    end
  end

  assign iss_entry_s.valid = hs_s;
  assign iss_entry_s.port  = grant_b_s;
  assign iss_entry_s.rev   = iss_op_s[1];

  generate
    if (SH_LATENCY == 0) begin : g_comb
      assign end_s       = iss_entry_s;
      assign pipe_busy_s = 1'b0;
    end else begin : g_pipe
      track_t pipe_r [SH_LATENCY];

      // Tracking pipeline mirrors the shifter latency
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SH_LATENCY; i++) begin
            pipe_r[i] <= '0;
          end
        end else begin
          pipe_r[0] <= iss_entry_s;
          for (int i = 1; i < SH_LATENCY; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      always_comb begin
        pipe_busy_s = 1'b0;
        for (int i = 0; i < SH_LATENCY; i++) begin
          pipe_busy_s = pipe_busy_s | pipe_r[i].valid;
        end
      end

      assign end_s = pipe_r[SH_LATENCY-1];
    end
  endgenerate

  assign result_s = end_s.rev ? bit_reverse32(sh_out) : sh_out;

  // Response registers: one-cycle pulse to the owner, the other port holds its data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_valid_r <= 1'b0;
      b_rsp_valid_r <= 1'b0;
      a_rsp_data_r  <= '0;
      b_rsp_data_r  <= '0;
    end else begin
      a_rsp_valid_r <= 1'b0;
      b_rsp_valid_r <= 1'b0;
      if (end_s.valid) begin
        if (end_s.port == PORT_B) begin
          b_rsp_valid_r <= 1'b1;
          b_rsp_data_r  <= result_s;
        end else begin
          a_rsp_valid_r <= 1'b1;
          a_rsp_data_r  <= result_s;
        end
      end
    end
  end

  assign a_rsp_valid = a_rsp_valid_r;
  assign b_rsp_valid = b_rsp_valid_r;
  assign a_rsp_data  = a_rsp_data_r;
  assign b_rsp_data  = b_rsp_data_r;
  assign busy        = pipe_busy_s | a_rsp_valid_r | b_rsp_valid_r;

endmodule

// File: tb/tb_shift_unit_sched.sv
// Bench for shift_unit_sched: two instances (latency 1 round-robin, latency 3
// fixed priority) share one stimulus stream and are checked against a queue model.
module tb_shift_unit_sched;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] a_data = 32'h0, b_data = 32'h0;
  logic [4:0]  a_amt = 5'h0, b_amt = 5'h0;
  logic [1:0]  a_op = 2'b00, b_op = 2'b00;

  logic [1:0]  a_ready_w, b_ready_w, a_rv_w, b_rv_w, busy_w, sh_rot_w;
  logic [31:0] a_rd_w [2];
  logic [31:0] b_rd_w [2];
  logic [31:0] sh_in_w [2];
  logic [31:0] sh_out_w [2];
  logic [4:0]  sh_sel_w [2];

  logic [31:0] st0;
  logic [31:0] st1 [3];

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [2][$];
  bit          last_b [2];
  logic [31:0] exp_ad [2];
  logic [31:0] exp_bd [2];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_unit_sched #(.SH_LATENCY(1), .FAIR(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready_w[0]), .a_data(a_data), .a_amt(a_amt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready_w[0]), .b_data(b_data), .b_amt(b_amt), .b_op(b_op),
    .a_rsp_valid(a_rv_w[0]), .a_rsp_data(a_rd_w[0]),
    .b_rsp_valid(b_rv_w[0]), .b_rsp_data(b_rd_w[0]),
    .sh_in(sh_in_w[0]), .sh_rotate(sh_rot_w[0]), .sh_select(sh_sel_w[0]),
    .sh_out(sh_out_w[0]), .busy(busy_w[0])
  );

  shift_unit_sched #(.SH_LATENCY(3), .FAIR(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready_w[1]), .a_data(a_data), .a_amt(a_amt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready_w[1]), .b_data(b_data), .b_amt(b_amt), .b_op(b_op),
    .a_rsp_valid(a_rv_w[1]), .a_rsp_data(a_rd_w[1]),
    .b_rsp_valid(b_rv_w[1]), .b_rsp_data(b_rd_w[1]),
    .sh_in(sh_in_w[1]), .sh_rotate(sh_rot_w[1]), .sh_select(sh_sel_w[1]),
    .sh_out(sh_out_w[1]), .busy(busy_w[1])
  );

  // Reference semantics: left ops and rotates straight from the op definitions
  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] d,
                                         input logic [4:0] amt);
    logic [63:0] w;
    w = {d, d};
    case (op)
      OP_SRL:  ref_op = d >> amt;
      OP_ROR:  begin w = w >> amt; ref_op = w[31:0]; end
      OP_SLL:  ref_op = d << amt;
      default: begin w = w << amt; ref_op = w[63:32]; end
    endcase
  endfunction

  // Stub right shifters with latency 1 and 3
  always @(posedge clk) begin
    st0    <= ref_op({1'b0, sh_rot_w[0]}, sh_in_w[0], sh_sel_w[0]);
    st1[0] <= ref_op({1'b0, sh_rot_w[1]}, sh_in_w[1], sh_sel_w[1]);
    st1[1] <= st1[0];
    st1[2] <= st1[1];
  end
  assign sh_out_w[0] = st0;
  assign sh_out_w[1] = st1[2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit fair_of(input int i);
    return (i == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Registered outputs against the model for the current cycle
  task automatic check_outputs(input int i);
    exp_t e;
    bit va, vb, bz;
    va = 1'b0;
    vb = 1'b0;
    bz = (exp_q[i].size() != 0);
    if (exp_q[i].size() > 0 && exp_q[i][0].due == cyc) begin
      e = exp_q[i].pop_front();
      if (e.port) begin vb = 1'b1; exp_bd[i] = e.data; end
      else begin va = 1'b1; exp_ad[i] = e.data; end
    end
    check($sformatf("d%0d.a_rsp_valid", i), {31'h0, a_rv_w[i]}, {31'h0, va});
    check($sformatf("d%0d.b_rsp_valid", i), {31'h0, b_rv_w[i]}, {31'h0, vb});
    check($sformatf("d%0d.a_rsp_data", i), a_rd_w[i], exp_ad[i]);
    check($sformatf("d%0d.b_rsp_data", i), b_rd_w[i], exp_bd[i]);
    check($sformatf("d%0d.busy", i), {31'h0, busy_w[i]}, {31'h0, bz});
  endtask

  // Expected grant and bookkeeping of the accepted request
  task automatic grant_model(input int i);
    bit ga, gb;
    ga = 1'b0;
    gb = 1'b0;
    if (a_valid && b_valid) begin
      if (fair_of(i)) begin ga = last_b[i]; gb = !last_b[i]; end
      else ga = 1'b1;
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
    check($sformatf("d%0d.a_ready", i), {31'h0, a_ready_w[i]}, {31'h0, ga});
    check($sformatf("d%0d.b_ready", i), {31'h0, b_ready_w[i]}, {31'h0, gb});
    if (ga) begin
      exp_q[i].push_back('{cyc + lat_of(i) + 1, 1'b0, ref_op(a_op, a_data, a_amt)});
      last_b[i] = 1'b0;
    end
    if (gb) begin
      exp_q[i].push_back('{cyc + lat_of(i) + 1, 1'b1, ref_op(b_op, b_data, b_amt)});
      last_b[i] = 1'b1;
    end
  endtask

  task automatic tick(input bit av, input logic [31:0] ad, input logic [4:0] aam,
                      input logic [1:0] aop, input bit bv, input logic [31:0] bd,
                      input logic [4:0] bam, input logic [1:0] bop);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_outputs(i);
    a_valid = av; a_data = ad; a_amt = aam; a_op = aop;
    b_valid = bv; b_data = bd; b_amt = bam; b_op = bop;
    #1;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) grant_model(i);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 32'h0, 5'h0, 2'b00, 1'b0, 32'h0, 5'h0, 2'b00);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      last_b[i] = 1'b1;
      exp_ad[i] = 32'h0;
      exp_bd[i] = 32'h0;
    end
  endtask

  task automatic reset_now();
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
    idle(2);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_sft [4];

  initial begin
    model_clear();
    idle(2);
    rst_n = 1'b1;

    // Tie on both ports: round-robin alternates, fixed priority keeps A
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 32'h8000_0000, 5'd31, OP_SRL, 1'b1, 32'h0000_0001, 5'd1, OP_ROL);
      check("rr_grant_a", {31'h0, a_ready_w[0]}, {31'h0, (k % 2 == 0)});
      check("fixed_grant_a", {31'h0, a_ready_w[1]}, 32'h1);
    end
    tick(1'b0, 32'h0, 5'h0, OP_SRL, 1'b1, 32'h0000_0001, 5'd1, OP_ROL);
    check("fixed_b_after_a", {31'h0, b_ready_w[1]}, 32'h1);
    idle(5);

    // A only, each op in turn
    exp_sft[0] = 32'h0F00_0000; exp_sft[1] = 32'h1F00_0000;
    exp_sft[2] = 32'h0000_0010; exp_sft[3] = 32'h0000_001F;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 32'hF000_0001, 5'd4, k[1:0], 1'b0, 32'h0, 5'h0, OP_SRL);
      idle(2);
      check("a_op_result", a_rd_w[0], exp_sft[k]);
      check("a_op_pulse", {31'h0, a_rv_w[0]}, 32'h1);
    end
    idle(3);

    // Amount zero is identity for every op
    for (int k = 0; k < 4; k++) tick(1'b1, 32'hDEAD_BEEF, 5'd0, k[1:0], 1'b0, 32'h0, 5'h0, OP_SRL);
    idle(6);
    check("amt0_result", a_rd_w[1], 32'hDEAD_BEEF);

    // Reset with operations in flight, then the first tie goes to A
    for (int k = 0; k < 3; k++) tick(1'b1, $urandom, 5'($urandom), 2'($urandom), 1'b0, 32'h0, 5'h0, OP_SRL);
    idle(1);
    reset_now();
    idle(5);
    tick(1'b1, 32'h1234_5678, 5'd3, OP_ROL, 1'b1, 32'h8765_4321, 5'd7, OP_SLL);
    check("post_reset_tie", {30'h0, a_ready_w}, 32'h3);
    idle(5);

    // Back-to-back stream for in-order return through the deep pipeline
    for (int k = 0; k < 5; k++) tick(1'b1, $urandom, 5'($urandom), 2'($urandom), 1'b0, 32'h0, 5'h0, OP_SRL);
    idle(6);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 2'($urandom),
           ($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 2'($urandom));
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit_sched.md
Name: shift_unit_sched

Overview:
- Scheduler that shares one external 32-bit right shifter/rotator between two requesters (port A, port B) using valid/ready handshakes.
- Arbitrates between the two ports and drives the shifter's data, rotate and amount inputs.
- Adds left shift and left rotate by bit-reversing the operand on the way in and the result on the way out.
- Tracks in-flight operations across the shifter's latency and returns each result to the port that issued it.

Parameters:
- SH_LATENCY, 1, clock cycles from the shifter's inputs to a valid sh_out (0..4; 0 = combinational shifter).
- FAIR, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  port A request valid.
- a_ready  output  1  port A request accepted this cycle.
- a_data  input  32  port A operand.
- a_amt  input  5  port A shift amount.
- a_op  input  2  port A op: 00 SRL, 01 ROR, 10 SLL, 11 ROL.
- b_valid, b_ready, b_data, b_amt, b_op  same as A, for port B.
- a_rsp_valid  output  1  one-cycle pulse: port A result valid.
- a_rsp_data  output  32  port A result.
- b_rsp_valid  output  1  one-cycle pulse: port B result valid.
- b_rsp_data  output  32  port B result.
- sh_in  output  32  operand to the shifter.
- sh_rotate  output  1  rotate enable to the shifter.
- sh_select  output  5  amount to the shifter.
- sh_out  input  32  shifter result.
- busy  output  1  at least one operation in flight.

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - a_rsp_valid, b_rsp_valid, busy = 0; a_rsp_data, b_rsp_data = 0.
  - In-flight pipeline emptied; last_grant = B, so A wins the first tie.
  - Reset mid-operation drops in-flight results; no rsp pulse may follow release.
- Arbitration (combinational, every cycle):
  - Only one valid: that port is granted.
  - Both valid, FAIR=1: grant the port not granted last. FAIR=0: grant A.
  - x_ready = grant to x. A handshake occurs when x_valid & x_ready.
  - last_grant updates only on a handshake.
- Ready ignores the in-flight count: the pipeline accepts one operation per cycle, no stalls. Responses have no backpressure.
- Issue (combinational in the handshake cycle):
  - sh_select = amt; sh_rotate = op[0].
  - sh_in = data for op[1]=0; bit-reverse(data) for op[1]=1.
  - With no handshake, sh_in, sh_select and sh_rotate hold their previous values (registered hold copy), which avoids shifter toggling.
- Tracking: a SH_LATENCY-deep shift register of {valid, port, op[1]}.
  - When an entry reaches the end, sh_out is captured, bit-reversed again if op[1]=1, and registered into the owning port's rsp_data.
  - That port's rsp_valid pulses for exactly one cycle. The other port's rsp_data holds its old value.
- Latency: rsp_valid rises SH_LATENCY+1 cycles after the handshake edge (2 for the default). Results return in issue order.
- Throughput: back-to-back handshakes produce back-to-back rsp pulses, possibly alternating between ports.
- busy = OR of the tracking valids and any rsp_valid.
- Amount 0: result equals the operand for every op.
- A request must hold data, amt and op stable while valid and not ready; changing them is a protocol error and is not checked.

Decomposition:
- Shared package (shift_pkg):
  - Op encodings OP_SRL=2'b00, OP_ROR=2'b01, OP_SLL=2'b10, OP_ROL=2'b11.
  - DATA_W=32, AMT_W=5.
  - bit_reverse32 function.
- One sub-module, shift_rr_arb: the 2-way round-robin arbiter with the FAIR parameter. It owns last_grant and outputs grant_a and grant_b.
- The tracking pipeline and the reversal logic stay in the top level.

Test Plan:
- A only, 0xF0000001, amt 4, each op in turn (SRL/ROR/SLL/ROL), SH_LATENCY=1 stub shifter -> a_rsp_data 0x0F000000 / 0x1F000000 / 0x00000010 / 0x0000001F. Each a_rsp_valid pulse arrives 2 cycles after its handshake; b_rsp_valid stays 0.
- A and B held valid for 4 cycles, FAIR=1, A=SRL 0x80000000 amt 31, B=ROL 0x00000001 amt 1 -> grants A,B,A,B. Responses alternate, 0x00000001 on A and 0x00000002 on B, one per cycle.
- Same stimulus with FAIR=0 -> a_ready=1 for all 4 cycles, b_ready=0; B granted in the first cycle after a_valid drops.
- Amount 0 for all four ops with data 0xDEADBEEF -> every result 0xDEADBEEF; busy deasserts 2 cycles after the last handshake.
- Issue 3 back-to-back requests, then assert rst_n=0 one cycle later -> no rsp pulses after reset; busy=0; first post-reset tie grants A.
- SH_LATENCY=3 with a matching stub -> rsp_valid arrives 4 cycles after each handshake; 5 consecutive results arrive in issue order.
